// File: rtl/byte_serial_adder_ctrl_pkg.sv
// Shared types and helpers for the byte-serial adder front-end.
// Used by byte_serial_adder_ctrl (SUBTRACT_EN selects the subtract option).
package byte_serial_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte index width, never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/byte_serial_adder_ctrl_adder.sv
// 8-bit generate/propagate carry adder with an enable gate.
// Outputs are forced to zero while enable is low.
module parallel_carry_adder_8bit_with_enable (
    input  logic       enable,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum  = enable ? (p ^ c[7:0]) : 8'h00;
    assign cout = enable & c[8];

endmodule

// File: rtl/byte_serial_adder_ctrl.sv
// Byte-serial wide adder: feeds one 8-bit adder LSB byte first.
// Define SUBTRACT_EN to add the in_sub port (A-B via inverted B, carry 1).
module byte_serial_adder_ctrl
    import byte_serial_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] in_a,
    input  logic [BYTE_W*NBYTES-1:0] in_b,
    input  logic                     in_cin,
`ifdef SUBTRACT_EN
    input  logic                     in_sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] out_sum,
    output logic                     out_cout,
    output logic                     busy
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int IW = clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;

    logic            inv;
    logic            first_carry;
    logic            add_en;
    logic [7:0]      add_a;
    logic [7:0]      add_b;
    logic            add_cin;
    logic [7:0]      add_sum;
    logic            add_cout;

`ifdef SUBTRACT_EN
    logic            sub_q;

    assign inv         = sub_q;
    assign first_carry = in_sub ? 1'b1 : in_cin;
`else
    assign inv         = 1'b0;
    assign first_carry = in_cin;
`endif

    assign in_ready = (state == IDLE);
    assign add_en   = (state == ADD);

    // The adder only sees operand bytes while ADD is active.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (add_en) begin
            add_a   = a_q[idx*BYTE_W +: BYTE_W];
            add_b   = b_q[idx*BYTE_W +: BYTE_W] ^ {BYTE_W{inv}};
            add_cin = carry;
        end
    end

    parallel_carry_adder_8bit_with_enable u_adder (
        .enable (add_en),
        .a      (add_a),
        .b      (add_b),
        .cin    (add_cin),
        .sum    (add_sum),
        .cout   (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef SUBTRACT_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        carry <= first_carry;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
`ifdef SUBTRACT_EN
                        sub_q <= in_sub;
`endif
                    end
                end
                ADD: begin
                    out_sum[idx*BYTE_W +: BYTE_W] <= add_sum;
                    carry <= add_cout;
                    idx   <= idx + IW'(1);
                    if (idx == LAST) begin
                        idx       <= '0;
                        out_cout  <= add_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// Directed self-checking bench for byte_serial_adder_ctrl (NBYTES=4).
// Subtract vectors run only when SUBTRACT_EN is defined.
module tb_byte_serial_adder_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
`ifdef SUBTRACT_EN
    logic        in_sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        busy;

    int n_checks;
    int n_fail;

    byte_serial_adder_ctrl #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef SUBTRACT_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for acceptance, then drop in_valid.
    task automatic start_op(input logic [31:0] a,
                            input logic [31:0] b,
                            input logic cin,
                            input logic sub);
        int k;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
`ifdef SUBTRACT_EN
        in_sub   = sub;
`else
        if (sub) $display("note: subtract requested without SUBTRACT_EN");
`endif
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) check("accept_timeout", 64'(k), 0);
        tick();
        in_valid = 1'b0;
    endtask

    // Cycles from the accepting edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (lat >= 50) check("result_timeout", 64'(lat), 0);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    int lat;
    int acc1, acc2, hs1, hs2;
    logic [31:0] s1, s2;
    logic        co1, co2;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
`ifdef SUBTRACT_EN
        in_sub    = 1'b0;
`endif
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready", 64'(in_ready), 1);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_sum", 64'(out_sum), 0);
        check("rst_out_cout", 64'(out_cout), 0);
        check("rst_busy", 64'(busy), 0);

        // 0xFF + 1: carry from byte 0 into byte 1
        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        check("t1_busy", 64'(busy), 1);
        wait_result(lat);
        check("t1_latency", 64'(lat), 4);
        check("t1_sum", 64'(out_sum), 64'h100);
        check("t1_cout", 64'(out_cout), 0);
        take_result();
        check("t1_valid_drop", 64'(out_valid), 0);
        check("t1_in_ready", 64'(in_ready), 1);
        check("t1_busy_drop", 64'(busy), 0);

        // all-ones + 0 + cin ripples through every byte
        start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        wait_result(lat);
        check("t2_latency", 64'(lat), 4);
        check("t2_sum", 64'(out_sum), 0);
        check("t2_cout", 64'(out_cout), 1);

        // Back-pressure: hold the result while new operands knock
        in_a = 32'h1234_5678;
        in_b = 32'h1111_1111;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            tick();
            check("t3_hold_valid", 64'(out_valid), 1);
            check("t3_hold_sum", 64'(out_sum), 0);
            check("t3_hold_cout", 64'(out_cout), 1);
            check("t3_hold_in_ready", 64'(in_ready), 0);
        end
        in_valid = 1'b0;
        take_result();
        check("t3_valid_drop", 64'(out_valid), 0);
        check("t3_in_ready", 64'(in_ready), 1);
        tick();
        check("t3_no_capture", 64'(busy), 0);

        // Reset two cycles into ADD aborts the transaction
        start_op(32'h1122_3344, 32'h0101_0101, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_in_ready", 64'(in_ready), 1);
        check("t4_sum_clear", 64'(out_sum), 0);
        check("t4_busy", 64'(busy), 0);
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) lat++;
            tick();
        end
        check("t4_no_valid", 64'(lat), 0);
        start_op(32'd3, 32'd4, 1'b0, 1'b0);
        wait_result(lat);
        check("t4_latency", 64'(lat), 4);
        check("t4_sum", 64'(out_sum), 7);
        check("t4_cout", 64'(out_cout), 0);
        take_result();

        // Back-to-back with out_ready tied high
        out_ready = 1'b1;
        in_a      = 32'd1;
        in_b      = 32'd2;
        in_cin    = 1'b0;
        in_valid  = 1'b1;
        acc1 = -1; acc2 = -1; hs1 = -1; hs2 = -1;
        s1 = '0; s2 = '0; co1 = 1'b0; co2 = 1'b0;
        for (int c = 0; c < 40 && hs2 < 0; c++) begin
            automatic logic acc = in_valid && in_ready;
            automatic logic hs  = out_valid && out_ready;
            automatic logic [31:0] s = out_sum;
            automatic logic co = out_cout;
            tick();
            if (acc) begin
                if (acc1 < 0) begin
                    acc1 = c;
                    in_a = 32'h8000_0000;
                    in_b = 32'h8000_0000;
                end else begin
                    acc2 = c;
                    in_valid = 1'b0;
                end
            end
            if (hs) begin
                if (hs1 < 0) begin
                    hs1 = c; s1 = s; co1 = co;
                end else begin
                    hs2 = c; s2 = s; co2 = co;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t5_acc1", 64'(acc1), 0);
        check("t5_hs1", 64'(hs1), 5);
        check("t5_sum1", 64'(s1), 3);
        check("t5_cout1", 64'(co1), 0);
        check("t5_acc2", 64'(acc2), 6);
        check("t5_hs2", 64'(hs2), 11);
        check("t5_sum2", 64'(s2), 0);
        check("t5_cout2", 64'(co2), 1);

`ifdef SUBTRACT_EN
        // Subtract: in_cin is ignored, so drive it low
        start_op(32'd5, 32'd7, 1'b0, 1'b1);
        wait_result(lat);
        check("t6_sum_borrow", 64'(out_sum), 64'hFFFF_FFFE);
        check("t6_cout_borrow", 64'(out_cout), 0);
        take_result();
        start_op(32'd7, 32'd5, 1'b0, 1'b1);
        wait_result(lat);
        check("t6_sum", 64'(out_sum), 2);
        check("t6_cout", 64'(out_cout), 1);
        take_result();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
